load_buffer: RTL and testbench

LOAD_BUFFER -- requirements
Module: load_buffer

---
 rtl/load_buffer_pkg.sv | 44 ++++
 rtl/load_buffer_if.sv | 42 ++++
 rtl/load_buffer_entry.sv | 49 ++++
 rtl/load_buffer.sv | 106 ++++++++++
 tb/tb_load_buffer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_buffer_pkg.sv
// Shared superscalar definitions for the load buffer: default depth, word width,
// the entry record, and the dual-CDB snoop rule used at insertion and while resident.
package load_buffer_pkg;

  localparam int LB_DEPTH = 4;
  localparam int DATA_W   = 32;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic  valid;
    logic  rdy;
    word_t tag;
    word_t data;
    word_t off;
    word_t dest;
    logic  regwrite;
  } lb_entry_t;

  // A waiting entry takes its base from the first CDB whose tag matches; Cdb0 has priority.
  function automatic lb_entry_t lb_snoop(
    input lb_entry_t e,
    input logic      c0_vld,
    input word_t     c0_tag,
    input word_t     c0_data,
    input logic      c1_vld,
    input word_t     c1_tag,
    input word_t     c1_data
  );
    lb_entry_t r;
    r = e;
    if (!e.rdy) begin
      if (c0_vld && (c0_tag == e.tag)) begin
        r.rdy  = 1'b1;
        r.data = c0_data;
      end else if (c1_vld && (c1_tag == e.tag)) begin
        r.rdy  = 1'b1;
        r.data = c1_data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/load_buffer_if.sv
// Issue, CDB, flush and load-stage signals of the load buffer, grouped into one bundle.
interface load_buffer_if
  import load_buffer_pkg::*;
#(
  parameter int DEPTH = LB_DEPTH
);

  logic                   IssueValid;
  logic                   IssueReady;
  word_t                  IssueBaseTag;
  word_t                  IssueBaseData;
  word_t                  IssueOffset;
  word_t                  IssueDest;
  logic                   IssueBaseRdy;
  logic                   IssueRegWrite;
  logic                   Cdb0Valid;
  word_t                  Cdb0Tag;
  word_t                  Cdb0Data;
  logic                   Cdb1Valid;
  word_t                  Cdb1Tag;
  word_t                  Cdb1Data;
  logic                   Flush;
  word_t                  A;
  word_t                  Dest;
  logic                   RegWrite;
  logic [$clog2(DEPTH):0] Count;

  modport master (
    output IssueValid, IssueBaseTag, IssueBaseData, IssueOffset, IssueDest,
           IssueBaseRdy, IssueRegWrite, Cdb0Valid, Cdb0Tag, Cdb0Data,
           Cdb1Valid, Cdb1Tag, Cdb1Data, Flush,
    input  IssueReady, A, Dest, RegWrite, Count
  );

  modport slave (
    input  IssueValid, IssueBaseTag, IssueBaseData, IssueOffset, IssueDest,
           IssueBaseRdy, IssueRegWrite, Cdb0Valid, Cdb0Tag, Cdb0Data,
           Cdb1Valid, Cdb1Tag, Cdb1Data, Flush,
    output IssueReady, A, Dest, RegWrite, Count
  );

endinterface

// File: rtl/load_buffer_entry.sv
// One load-buffer slot: holds a load record and snoops both CDBs for its base tag,
// both on the insertion cycle and every cycle while it waits.
module load_buffer_entry
  import load_buffer_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_flush,
  input  logic      i_wr,
  input  logic      i_free,
  input  lb_entry_t i_wr_entry,
  input  logic      i_cdb0_vld,
  input  word_t     i_cdb0_tag,
  input  word_t     i_cdb0_data,
  input  logic      i_cdb1_vld,
  input  word_t     i_cdb1_tag,
  input  word_t     i_cdb1_data,
  output lb_entry_t o_entry
);

  lb_entry_t r_ent;
  lb_entry_t w_ins;
  lb_entry_t w_cur;

  always_comb begin
    w_ins = lb_snoop(i_wr_entry, i_cdb0_vld, i_cdb0_tag, i_cdb0_data,
                     i_cdb1_vld, i_cdb1_tag, i_cdb1_data);
    w_cur = lb_snoop(r_ent, i_cdb0_vld, i_cdb0_tag, i_cdb0_data,
                     i_cdb1_vld, i_cdb1_tag, i_cdb1_data);
  end

  // Insert and free never target the same slot: an empty slot is never the dispatching head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent <= '0;
    end else if (i_flush) begin
      r_ent <= '0;
    end else if (i_wr) begin
      r_ent <= w_ins;
    end else if (i_free) begin
      r_ent <= '0;
    end else if (r_ent.valid) begin
      r_ent <= w_cur;
    end
  end

  assign o_entry = r_ent;

endmodule

// File: rtl/load_buffer.sv
// In-order load buffer: circular FIFO of loads waiting on their base register,
// dispatching the head as a registered address/destination to the load stage.
module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int DEPTH = LB_DEPTH
)(
  input  logic          CLK,
  input  logic          Reset,
  load_buffer_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  word_t         r_a;
  word_t         r_dest;
  logic          r_rw;

  lb_entry_t     w_ent [DEPTH];
  lb_entry_t     w_head_ent;
  lb_entry_t     w_issue_ent;
  logic          w_ready;
  logic          w_ins;
  logic          w_disp;

  assign w_ready    = (r_count < CW'(DEPTH));
  assign w_head_ent = w_ent[r_head];
  assign w_ins      = bus.IssueValid && w_ready && !bus.Flush;
  assign w_disp     = w_head_ent.valid && w_head_ent.rdy && !bus.Flush;

  always_comb begin
    w_issue_ent          = '0;
    w_issue_ent.valid    = 1'b1;
    w_issue_ent.rdy      = bus.IssueBaseRdy;
    w_issue_ent.tag      = bus.IssueBaseTag;
    w_issue_ent.data     = bus.IssueBaseData;
    w_issue_ent.off      = bus.IssueOffset;
    w_issue_ent.dest     = bus.IssueDest;
    w_issue_ent.regwrite = bus.IssueRegWrite;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    load_buffer_entry u_ent (
      .clk         (CLK),
      .rst_n       (Reset),
      .i_flush     (bus.Flush),
      .i_wr        (w_ins && (r_tail == PW'(g))),
      .i_free      (w_disp && (r_head == PW'(g))),
      .i_wr_entry  (w_issue_ent),
      .i_cdb0_vld  (bus.Cdb0Valid),
      .i_cdb0_tag  (bus.Cdb0Tag),
      .i_cdb0_data (bus.Cdb0Data),
      .i_cdb1_vld  (bus.Cdb1Valid),
      .i_cdb1_tag  (bus.Cdb1Tag),
      .i_cdb1_data (bus.Cdb1Data),
      .o_entry     (w_ent[g])
    );
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.Flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_ins)  r_tail <= r_tail + PW'(1);
      if (w_disp) r_head <= r_head + PW'(1);
      case ({w_ins, w_disp})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Load-stage register: A/Dest hold on bubbles, only RegWrite drops.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_a    <= '0;
      r_dest <= '0;
      r_rw   <= 1'b0;
    end else if (w_disp) begin
      r_a    <= w_head_ent.data + w_head_ent.off;
      r_dest <= w_head_ent.dest;
      r_rw   <= w_head_ent.regwrite;
    end else begin
      r_rw   <= 1'b0;
    end
  end

  assign bus.IssueReady = w_ready;
  assign bus.Count      = r_count;
  assign bus.A          = r_a;
  assign bus.Dest       = r_dest;
  assign bus.RegWrite   = r_rw;

endmodule

// File: tb/tb_load_buffer.sv
// Bench for load_buffer: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based model of the buffer.
module tb_load_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] tag;
    logic [31:0] data;
    logic [31:0] off;
    logic [31:0] dest;
    logic        rw;
    logic        rdy;
  } ment_t;

  logic CLK;
  logic Reset;
  int   n_checks;
  int   n_err;
  bit   chk_en;

  ment_t       mq[$];
  ment_t       m_new;
  logic [31:0] m_a;
  logic [31:0] m_dest;
  logic        m_rw;
  bit          m_disp;
  bit          m_ins;

  load_buffer_if #(.DEPTH(DEPTH)) bus ();

  load_buffer #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic ment_t snoop(ment_t e);
    ment_t r;
    r = e;
    if (!e.rdy) begin
      if (bus.Cdb0Valid && bus.Cdb0Tag == e.tag) begin
        r.rdy = 1'b1; r.data = bus.Cdb0Data;
      end else if (bus.Cdb1Valid && bus.Cdb1Tag == e.tag) begin
        r.rdy = 1'b1; r.data = bus.Cdb1Data;
      end
    end
    return r;
  endfunction

  // Model: a FIFO of loads; the oldest dispatches when ready, all waiting ones snoop.
  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mq.delete();
      m_a = '0; m_dest = '0; m_rw = 1'b0;
    end else if (bus.Flush) begin
      mq.delete();
      m_rw = 1'b0;
    end else begin
      m_disp = (mq.size() > 0) && mq[0].rdy;
      m_ins  = bus.IssueValid && (mq.size() < DEPTH);
      if (m_disp) begin
        m_a    = mq[0].data + mq[0].off;
        m_dest = mq[0].dest;
        m_rw   = mq[0].rw;
        mq.delete(0);
      end else begin
        m_rw = 1'b0;
      end
      foreach (mq[i]) mq[i] = snoop(mq[i]);
      if (m_ins) begin
        m_new.tag  = bus.IssueBaseTag;
        m_new.data = bus.IssueBaseData;
        m_new.off  = bus.IssueOffset;
        m_new.dest = bus.IssueDest;
        m_new.rw   = bus.IssueRegWrite;
        m_new.rdy  = bus.IssueBaseRdy;
        mq.push_back(snoop(m_new));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en && Reset) begin
      chk("cmp_RegWrite", {31'd0, bus.RegWrite}, {31'd0, m_rw});
      chk("cmp_A", bus.A, m_a);
      chk("cmp_Dest", bus.Dest, m_dest);
      chk("cmp_Count", 32'(bus.Count), 32'(mq.size()));
      chk("cmp_IssueReady", {31'd0, bus.IssueReady}, {31'd0, (mq.size() < DEPTH)});
    end
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    bus.IssueValid = 0; bus.IssueBaseTag = 0; bus.IssueBaseData = 0;
    bus.IssueOffset = 0; bus.IssueDest = 0; bus.IssueBaseRdy = 0; bus.IssueRegWrite = 0;
    bus.Cdb0Valid = 0; bus.Cdb0Tag = 0; bus.Cdb0Data = 0;
    bus.Cdb1Valid = 0; bus.Cdb1Tag = 0; bus.Cdb1Data = 0;
    bus.Flush = 0;
  endtask

  task automatic issue(input logic [31:0] tag, input logic [31:0] data, input logic [31:0] off,
                       input logic [31:0] dest, input logic rdy, input logic rw);
    bus.IssueValid = 1; bus.IssueBaseTag = tag; bus.IssueBaseData = data;
    bus.IssueOffset = off; bus.IssueDest = dest; bus.IssueBaseRdy = rdy; bus.IssueRegWrite = rw;
  endtask

  task automatic cdb0(input logic v, input logic [31:0] t, input logic [31:0] d);
    bus.Cdb0Valid = v; bus.Cdb0Tag = t; bus.Cdb0Data = d;
  endtask

  task automatic cdb1(input logic v, input logic [31:0] t, input logic [31:0] d);
    bus.Cdb1Valid = v; bus.Cdb1Tag = t; bus.Cdb1Data = d;
  endtask

  task automatic out3(input string n, input logic [31:0] a, input logic [31:0] d, input logic rw);
    chk({n, "_A"}, bus.A, a);
    chk({n, "_Dest"}, bus.Dest, d);
    chk({n, "_RegWrite"}, {31'd0, bus.RegWrite}, {31'd0, rw});
  endtask

  initial begin
    n_checks = 0; n_err = 0; chk_en = 0;
    Reset = 0;
    idle();
    step(); step();
    out3("reset", 32'h0, 32'h0, 1'b0);
    chk("reset_Count", 32'(bus.Count), 32'd0);
    chk("reset_IssueReady", {31'd0, bus.IssueReady}, 32'd1);
    Reset = 1; chk_en = 1;
    step();

    // Ready load: two-cycle latency
    issue(32'd1, 32'h100, 32'h8, 32'd5, 1'b1, 1'b1);
    step(); idle();
    chk("t1_Count1", 32'(bus.Count), 32'd1);
    chk("t1_bubble", {31'd0, bus.RegWrite}, 32'd0);
    step();
    out3("t1", 32'h108, 32'd5, 1'b1);
    chk("t1_model_A", m_a, 32'h108);
    chk("t1_Count0", 32'(bus.Count), 32'd0);
    step();
    out3("t1_hold", 32'h108, 32'd5, 1'b0);

    // Wait on tag 7, released by Cdb1
    issue(32'd7, 32'hdead, 32'h10, 32'd6, 1'b0, 1'b1);
    step(); idle();
    cdb1(1'b1, 32'd7, 32'h2000);
    step(); idle();
    chk("t2_wait", {31'd0, bus.RegWrite}, 32'd0);
    step();
    out3("t2", 32'h2010, 32'd6, 1'b1);

    // Fill, reject fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      issue(32'd20 + i, 32'h0, i, 32'd40 + i, 1'b0, 1'b1);
      step();
    end
    idle();
    chk("t3_full_Count", 32'(bus.Count), 32'd4);
    chk("t3_full_Ready", {31'd0, bus.IssueReady}, 32'd0);
    issue(32'd24, 32'h999, 32'h0, 32'd44, 1'b1, 1'b1);
    step(); idle();
    chk("t3_fifth_ignored", 32'(bus.Count), 32'd4);
    cdb0(1'b1, 32'd20, 32'h1000); cdb1(1'b1, 32'd21, 32'h1100);
    step();
    cdb0(1'b1, 32'd22, 32'h1200); cdb1(1'b1, 32'd23, 32'h1300);
    step(); idle();
    out3("t3_d0", 32'h1000, 32'd40, 1'b1);
    chk("t3_Count3", 32'(bus.Count), 32'd3);
    step(); out3("t3_d1", 32'h1101, 32'd41, 1'b1);
    step(); out3("t3_d2", 32'h1202, 32'd42, 1'b1);
    step(); out3("t3_d3", 32'h1303, 32'd43, 1'b1);
    chk("t3_empty", 32'(bus.Count), 32'd0);
    step();

    // Non-ready head blocks a ready younger entry
    issue(32'd3, 32'h0, 32'h4, 32'd50, 1'b0, 1'b1);
    step();
    issue(32'd4, 32'h500, 32'h1, 32'd51, 1'b1, 1'b1);
    step(); idle();
    step();
    chk("t4_blocked", {31'd0, bus.RegWrite}, 32'd0);
    chk("t4_Count2", 32'(bus.Count), 32'd2);
    cdb0(1'b1, 32'd3, 32'h300);
    step(); idle();
    chk("t4_still_blocked", {31'd0, bus.RegWrite}, 32'd0);
    step(); out3("t4_head", 32'h304, 32'd50, 1'b1);
    step(); out3("t4_young", 32'h501, 32'd51, 1'b1);
    step();

    // Double CDB match (Cdb0 wins), then insertion-time capture
    issue(32'd9, 32'h0, 32'h0, 32'd60, 1'b0, 1'b1);
    step(); idle();
    cdb0(1'b1, 32'd9, 32'h11); cdb1(1'b1, 32'd9, 32'h22);
    step(); idle();
    step(); out3("t5_prio", 32'h11, 32'd60, 1'b1);
    issue(32'd12, 32'h0, 32'h2, 32'd61, 1'b0, 1'b1);
    cdb1(1'b1, 32'd12, 32'h40);
    step(); idle();
    step(); out3("t5_inscap", 32'h42, 32'd61, 1'b1);
    step();

    // Flush with a pending dispatch
    for (int i = 0; i < 3; i++) begin
      issue(32'd30 + i, 32'h0, 32'h0, 32'd70 + i, 1'b0, 1'b1);
      step();
    end
    idle();
    cdb0(1'b1, 32'd30, 32'h3000);
    step(); idle();
    bus.Flush = 1;
    issue(32'd33, 32'h1, 32'h1, 32'd73, 1'b1, 1'b1);
    step(); idle();
    chk("t6_flush_Count", 32'(bus.Count), 32'd0);
    chk("t6_flush_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
    step();
    chk("t6_after_RegWrite", {31'd0, bus.RegWrite}, 32'd0);

    // Asynchronous reset mid-stream
    issue(32'd1, 32'h700, 32'h7, 32'd77, 1'b1, 1'b1);
    step(); idle();
    step();
    out3("t6_pre_reset", 32'h707, 32'd77, 1'b1);
    issue(32'd2, 32'h0, 32'h0, 32'd78, 1'b0, 1'b1);
    #2 Reset = 0;
    #1;
    out3("t6_async", 32'h0, 32'h0, 1'b0);
    chk("t6_async_Count", 32'(bus.Count), 32'd0);
    chk("t6_async_Ready", {31'd0, bus.IssueReady}, 32'd1);
    @(negedge CLK);
    idle();
    Reset = 1;
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.IssueValid    = ($urandom_range(0, 1) == 1);
      bus.IssueBaseTag  = $urandom_range(0, 7);
      bus.IssueBaseData = $urandom;
      bus.IssueOffset   = $urandom;
      bus.IssueDest     = $urandom_range(0, 63);
      bus.IssueBaseRdy  = ($urandom_range(0, 2) == 0);
      bus.IssueRegWrite = ($urandom_range(0, 3) != 0);
      bus.Cdb0Valid     = ($urandom_range(0, 1) == 1);
      bus.Cdb0Tag       = $urandom_range(0, 7);
      bus.Cdb0Data      = $urandom;
      bus.Cdb1Valid     = ($urandom_range(0, 1) == 1);
      bus.Cdb1Tag       = $urandom_range(0, 7);
      bus.Cdb1Data      = $urandom;
      bus.Flush         = ($urandom_range(0, 63) == 0);
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
